seq_scan_ctrl: RTL

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seq_scan_ctrl.sv
// Word-serial scanner: shifts each accepted word MSB first through a Mealy
// non-overlapping 1010 detector and reports per-word match count/positions.
// Optional SEQ_SCAN_CARRY_EN keeps detector state across word boundaries.
module seq_scan_ctrl #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic [WIDTH-1:0] out_pos,
  input  logic             clr_total,
  output logic [15:0]      total_count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_e;
  typedef enum logic [1:0] {DET_A, DET_B, DET_C, DET_D} det_e;

  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH);
  localparam logic [WIDTH-1:0] TOP_BIT  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  det_e             det_q, det_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [15:0]      total_q, total_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             bit_in, match;

  assign bit_in = sh_q[WIDTH-1];

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    det_d     = det_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    count_d   = count_q;
    pos_d     = pos_q;
    match     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d      = in_data;
          bit_cnt_d = '0;
          count_d   = '0;
          pos_d     = '0;
          state_d   = SHIFT;
`ifndef SEQ_SCAN_CARRY_EN
          det_d     = DET_A;
`endif
        end
      end
      SHIFT: begin
        // The cycle after the last bit only hands off to REPORT; the detector holds.
        if (bit_cnt_q == LAST_CNT) begin
          state_d = REPORT;
        end else begin
          sh_d      = sh_q << 1;
          bit_cnt_d = bit_cnt_q + CW'(1);
          case (det_q)
            DET_A: det_d = bit_in ? DET_B : DET_A;
            DET_B: det_d = bit_in ? DET_B : DET_C;
            DET_C: det_d = bit_in ? DET_D : DET_A;
            DET_D: begin
              det_d = bit_in ? DET_B : DET_A;
              match = !bit_in;
            end
            default: det_d = DET_A;
          endcase
          if (match) begin
            count_d = count_q + CW'(1);
            pos_d   = pos_q | (TOP_BIT >> bit_cnt_q);
          end
        end
      end
      REPORT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear has priority over a coincident match; the count saturates.
    total_d = total_q;
    if (clr_total)                      total_d = '0;
    else if (match && total_q != '1)    total_d = total_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (rst) begin
      state_q     <= IDLE;
      det_q       <= DET_A;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      count_q     <= '0;
      pos_q       <= '0;
      total_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      det_q       <= det_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      count_q     <= count_d;
      pos_q       <= pos_d;
      total_q     <= total_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == REPORT);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign out_count   = count_q;
  assign out_pos     = pos_q;
  assign total_count = total_q;

endmodule
